// File: rtl/buzz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buzz_pkg : shared types, defaults and tolerance helper for buzz_det  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package buzz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int unsigned DEF_N        = 50000;
  localparam int unsigned DEF_W        = 17;
  localparam int unsigned DEF_TOL      = 500;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_TIMEOUT  = 100000;

  // Subtract the smaller from the larger so no signed wrap can occur.
  function automatic logic within_tol(input logic [31:0] measured,
                                      input logic [31:0] n,
                                      input logic [31:0] tol);
    logic [31:0] diff;
    diff = (measured >= n) ? (measured - n) : (n - measured);
    return (diff <= tol);
  endfunction

endpackage
`default_nettype wire

// File: rtl/buzz_detector_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_edge : 2-flop synchronizer plus delay flop, any-edge detect     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic edge_pulse
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign edge_pulse = sync_q ^ dly_q;

endmodule
`default_nettype wire

// File: rtl/buzz_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buzz_detector : measures buzzer half-periods, reports lock and loss  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module buzz_detector
  import buzz_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned W        = DEF_W,
  parameter int unsigned TOL      = DEF_TOL,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         buzz_in,
  output logic [W-1:0] half_period,
  output logic         period_valid,
  output logic         locked,
  output logic         lost
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]  TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0]  TO_LAST_W = W'(TIMEOUT - 1);
  localparam logic [MW-1:0] LOCK_W    = MW'(LOCK_CNT);

  logic          edge_det;
  logic [W-1:0]  meas;
  logic          meas_ok;
  logic          timeout;

  state_e        state_q,  state_d;
  logic [W-1:0]  cnt_q,    cnt_d;
  logic [MW-1:0] match_q,  match_d;
  logic [W-1:0]  hp_q,     hp_d;
  logic          pv_q,     pv_d;
  logic          locked_q, locked_d;
  logic          lost_q,   lost_d;

  sync_edge u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .async_in   (buzz_in),
    .edge_pulse (edge_det)
  );

  always_comb begin
    meas     = cnt_q + 1'b1;
    meas_ok  = within_tol(32'(meas), 32'(N), 32'(TOL));
    // An edge in the final cycle takes priority over the timeout.
    timeout  = !edge_det && (cnt_q == TO_LAST_W) && (state_q != IDLE);

    cnt_d    = edge_det ? '0 : ((cnt_q == TIMEOUT_W) ? cnt_q : cnt_q + 1'b1);
    state_d  = state_q;
    match_d  = match_q;
    hp_d     = hp_q;
    pv_d     = 1'b0;
    lost_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = MEAS;
          match_d = '0;
        end
      end
      MEAS: begin
        if (edge_det) begin
          hp_d = meas;
          pv_d = 1'b1;
          if (meas_ok) begin
            if ((match_q + 1'b1) == LOCK_W) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end else if (timeout) begin
          state_d = IDLE;
          match_d = '0;
          lost_d  = 1'b1;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          hp_d = meas;
          pv_d = 1'b1;
          if (!meas_ok) begin
            state_d = MEAS;
            match_d = '0;
          end
        end else if (timeout) begin
          state_d = IDLE;
          match_d = '0;
          lost_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        match_d = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      match_q  <= '0;
      hp_q     <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      hp_q     <= hp_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign half_period  = hp_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_buzz_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_buzz_detector : randomized and directed checks vs interval model  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_buzz_detector;

  localparam int N        = 20;
  localparam int W        = 8;
  localparam int TOL      = 2;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 40;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         buzz_in = 1'b0;
  logic [W-1:0] half_period;
  logic         period_valid;
  logic         locked;
  logic         lost;

  buzz_detector #(
    .N(N), .W(W), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .buzz_in      (buzz_in),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int obs_hp[$];
  int obs_lk[$];
  int exp_hp[$];
  int exp_lk[$];
  int obs_lost = 0;
  int exp_lost = 0;
  int last_pv_cyc = 0;
  int lost_cyc = 0;
  int lost_hp = 0;
  int lost_lk = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (period_valid) begin
        obs_hp.push_back(int'(half_period));
        obs_lk.push_back(int'(locked));
        last_pv_cyc = cyc;
      end
      if (lost) begin
        obs_lost++;
        lost_cyc = cyc;
        lost_hp  = int'(half_period);
        lost_lk  = int'(locked);
      end
    end
  end

  // Reference model: works purely on the interval between input toggles.
  bit m_active = 1'b0;
  bit m_locked = 1'b0;
  int m_run    = 0;
  int last_cyc = 0;

  task automatic model_edge();
    int iv;
    bit ok;
    iv = cyc - last_cyc;
    last_cyc = cyc;
    if (m_active && iv > TIMEOUT) begin
      exp_lost++;
      m_active = 1'b0;
      m_locked = 1'b0;
    end
    if (!m_active) begin
      m_active = 1'b1;
      m_run    = 0;
    end else begin
      ok = (iv >= N - TOL) && (iv <= N + TOL);
      if (m_locked) begin
        if (!ok) begin
          m_locked = 1'b0;
          m_run    = 0;
        end
      end else if (ok) begin
        m_run++;
        if (m_run == LOCK_CNT) m_locked = 1'b1;
      end else begin
        m_run = 0;
      end
      exp_hp.push_back(iv);
      exp_lk.push_back(int'(m_locked));
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic toggle(input int k);
    step(k);
    buzz_in = ~buzz_in;
    model_edge();
  endtask

  task automatic settle();
    step(6);
    if (m_active && (cyc - last_cyc) > TIMEOUT + 4) begin
      exp_lost++;
      m_active = 1'b0;
      m_locked = 1'b0;
    end
  endtask

  task automatic clear_q();
    obs_hp.delete(); obs_lk.delete(); exp_hp.delete(); exp_lk.delete();
  endtask

  task automatic test_reset();
    step(3);
    total++;
    if (half_period !== '0) begin bad++; $display("FAIL reset_hp: got %0d want 0", half_period); end
    total++;
    if ({period_valid, locked, lost} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {period_valid, locked, lost});
    end
    rstn = 1'b1;
    step(2);
  endtask

  task automatic test_lock();
    toggle(5);
    repeat (4) toggle(20);
    settle();
    total++;
    if (obs_hp.size() !== 4) begin bad++; $display("FAIL lock_count: got %0d want 4", obs_hp.size()); end
    foreach (exp_hp[i]) if (i < obs_hp.size()) begin
      total++;
      if (obs_hp[i] !== exp_hp[i] || obs_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL lock[%0d]: got hp=%0d lk=%0d want hp=%0d lk=%0d", i, obs_hp[i], obs_lk[i], exp_hp[i], exp_lk[i]);
      end
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_level: got %b want 1", locked); end
    clear_q();
  endtask

  task automatic test_mismatch();
    toggle(25);
    repeat (4) toggle(20);
    settle();
    total++;
    if (obs_hp.size() !== exp_hp.size()) begin bad++; $display("FAIL mism_count: got %0d want %0d", obs_hp.size(), exp_hp.size()); end
    foreach (exp_hp[i]) if (i < obs_hp.size()) begin
      total++;
      if (obs_hp[i] !== exp_hp[i] || obs_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL mism[%0d]: got hp=%0d lk=%0d want hp=%0d lk=%0d", i, obs_hp[i], obs_lk[i], exp_hp[i], exp_lk[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_tolerance();
    step(60); settle();
    toggle(5);
    toggle(18); toggle(22); toggle(18); toggle(22);
    settle();
    step(60); settle();
    toggle(5);
    toggle(17); toggle(20); toggle(20); toggle(20); toggle(23); toggle(20); toggle(20);
    settle();
    total++;
    if (obs_hp.size() !== exp_hp.size()) begin bad++; $display("FAIL tol_count: got %0d want %0d", obs_hp.size(), exp_hp.size()); end
    foreach (exp_hp[i]) if (i < obs_hp.size()) begin
      total++;
      if (obs_hp[i] !== exp_hp[i] || obs_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL tol[%0d]: got hp=%0d lk=%0d want hp=%0d lk=%0d", i, obs_hp[i], obs_lk[i], exp_hp[i], exp_lk[i]);
      end
    end
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL tol_nolock: got %b want 0", locked); end
    total++;
    if (obs_lost !== exp_lost) begin bad++; $display("FAIL tol_lost: got %0d want %0d", obs_lost, exp_lost); end
    clear_q();
  endtask

  task automatic test_timeout();
    step(60); settle();
    toggle(5);
    repeat (4) toggle(20);
    step(60); settle();
    total++;
    if (obs_lost !== exp_lost) begin bad++; $display("FAIL to_count: got %0d want %0d", obs_lost, exp_lost); end
    total++;
    if (lost_cyc - last_pv_cyc !== TIMEOUT) begin
      bad++; $display("FAIL to_delay: got %0d want %0d", lost_cyc - last_pv_cyc, TIMEOUT);
    end
    total++;
    if (lost_lk !== 0 || locked !== 1'b0) begin bad++; $display("FAIL to_locked: got %0d/%b want 0/0", lost_lk, locked); end
    total++;
    if (lost_hp !== N || half_period !== W'(N)) begin
      bad++; $display("FAIL to_hp_hold: got %0d/%0d want %0d", lost_hp, half_period, N);
    end
    foreach (exp_hp[i]) if (i < obs_hp.size()) begin
      total++;
      if (obs_hp[i] !== exp_hp[i] || obs_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL to[%0d]: got hp=%0d lk=%0d want hp=%0d lk=%0d", i, obs_hp[i], obs_lk[i], exp_hp[i], exp_lk[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_edge_at_timeout();
    toggle(5);
    toggle(20);
    toggle(TIMEOUT);
    settle();
    total++;
    if (obs_hp.size() !== 2) begin bad++; $display("FAIL eat_count: got %0d want 2", obs_hp.size()); end
    foreach (exp_hp[i]) if (i < obs_hp.size()) begin
      total++;
      if (obs_hp[i] !== exp_hp[i] || obs_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL eat[%0d]: got hp=%0d lk=%0d want hp=%0d lk=%0d", i, obs_hp[i], obs_lk[i], exp_hp[i], exp_lk[i]);
      end
    end
    total++;
    if (obs_lost !== exp_lost) begin bad++; $display("FAIL eat_lost: got %0d want %0d", obs_lost, exp_lost); end
    clear_q();
  endtask

  task automatic test_reset_mid_lock();
    repeat (4) toggle(20);
    if (buzz_in) toggle(20);
    settle();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL rml_prelock: got %b want 1", locked); end
    clear_q();
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({half_period, period_valid, locked, lost} !== '0) begin
      bad++; $display("FAIL rml_async_clear: got hp=%0d pv=%b lk=%b lost=%b want all 0", half_period, period_valid, locked, lost);
    end
    step(3);
    rstn = 1'b1;
    m_active = 1'b0; m_locked = 1'b0; m_run = 0;
    toggle(5);
    repeat (4) toggle(20);
    settle();
    total++;
    if (obs_hp.size() !== 4) begin bad++; $display("FAIL rml_count: got %0d want 4", obs_hp.size()); end
    foreach (exp_hp[i]) if (i < obs_hp.size()) begin
      total++;
      if (obs_hp[i] !== exp_hp[i] || obs_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL rml[%0d]: got hp=%0d lk=%0d want hp=%0d lk=%0d", i, obs_hp[i], obs_lk[i], exp_hp[i], exp_lk[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 60; n++) begin
      k = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(15, 26));
      toggle(k);
    end
    settle();
    total++;
    if (obs_hp.size() !== exp_hp.size()) begin bad++; $display("FAIL rnd_count: got %0d want %0d", obs_hp.size(), exp_hp.size()); end
    foreach (exp_hp[i]) if (i < obs_hp.size()) begin
      total++;
      if (obs_hp[i] !== exp_hp[i] || obs_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL rnd[%0d]: got hp=%0d lk=%0d want hp=%0d lk=%0d", i, obs_hp[i], obs_lk[i], exp_hp[i], exp_lk[i]);
      end
    end
    total++;
    if (obs_lost !== exp_lost) begin bad++; $display("FAIL rnd_lost: got %0d want %0d", obs_lost, exp_lost); end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_tolerance();
    test_timeout();
    test_edge_at_timeout();
    test_reset_mid_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
